// File: rtl/wb_regfile_writer_if.sv
// rtl/wb_regfile_writer_if.sv - MEM-to-writeback request handshake bundle
interface wb_regfile_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_RegWrite;
  logic [4:0]  in_Write_register;
  logic [1:0]  in_MemtoReg;
  logic [2:0]  in_LoadType;
  logic [31:0] in_ALU_out;
  logic [31:0] in_Mem_data;
  logic [31:0] in_PC_plus4;

  // MEM stage side: offers requests and watches in_ready
  modport master (
    output in_valid, in_RegWrite, in_Write_register, in_MemtoReg,
           in_LoadType, in_ALU_out, in_Mem_data, in_PC_plus4,
    input  in_ready
  );

  // Writeback side: accepts requests
  modport slave (
    input  in_valid, in_RegWrite, in_Write_register, in_MemtoReg,
           in_LoadType, in_ALU_out, in_Mem_data, in_PC_plus4,
    output in_ready
  );
endinterface

// File: rtl/wb_regfile_writer.sv
// rtl/wb_regfile_writer.sv - writeback value select, load extension and 2-entry write FIFO
module wb_regfile_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  wb_regfile_writer_if.slave req,
  input  logic              rf_hold,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data,
  output logic              pending
);

  logic [1:0]        count;
  logic [ADDR_W-1:0] q_reg  [0:1];
  logic [DATA_W-1:0] q_data [0:1];

  logic              xfer;
  logic              keep;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] new_data;

  // in_ready depends on registered occupancy only
  assign req.in_ready = (count < 2'(DEPTH));
  assign xfer         = req.in_valid && req.in_ready;
  // Requests that write nothing (or target $0) are swallowed at acceptance
  assign keep         = xfer && req.in_RegWrite && (req.in_Write_register != '0);
  assign pending      = (count != 2'd0) || RegWrite;

  // Resolve the final write value at acceptance so the FIFO holds ready-to-write data
  always_comb begin
    ld_byte  = req.in_Mem_data[7:0];
    ld_half  = req.in_ALU_out[1] ? req.in_Mem_data[31:16] : req.in_Mem_data[15:0];
    ld_val   = req.in_Mem_data;
    new_data = req.in_ALU_out;
    case (req.in_ALU_out[1:0])
      2'd0:    ld_byte = req.in_Mem_data[7:0];
      2'd1:    ld_byte = req.in_Mem_data[15:8];
      2'd2:    ld_byte = req.in_Mem_data[23:16];
      default: ld_byte = req.in_Mem_data[31:24];
    endcase
    case (req.in_LoadType)
      3'b001:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_val = {24'd0, ld_byte};
      3'b011:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {16'd0, ld_half};
      default: ld_val = req.in_Mem_data;
    endcase
    case (req.in_MemtoReg)
      2'b01:   new_data = ld_val;
      2'b10:   new_data = req.in_PC_plus4;
      default: new_data = req.in_ALU_out;
    endcase
  end

  // Output register and FIFO: pop head when the port is free, bypass when empty,
  // and always leave index/data zero on a bubble since the register file forwards them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count          <= 2'd0;
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
      q_reg[0]       <= '0;
      q_reg[1]       <= '0;
      q_data[0]      <= '0;
      q_data[1]      <= '0;
    end else if (!rf_hold) begin
      if (count != 2'd0) begin
        RegWrite       <= 1'b1;
        Write_register <= q_reg[0];
        Write_data     <= q_data[0];
        q_reg[0]       <= q_reg[1];
        q_data[0]      <= q_data[1];
        if (keep) begin
          if (count == 2'd1) begin
            q_reg[0]  <= req.in_Write_register;
            q_data[0] <= new_data;
          end else begin
            q_reg[1]  <= req.in_Write_register;
            q_data[1] <= new_data;
          end
        end else begin
          count <= count - 2'd1;
        end
      end else if (keep) begin
        RegWrite       <= 1'b1;
        Write_register <= req.in_Write_register;
        Write_data     <= new_data;
      end else begin
        RegWrite       <= 1'b0;
        Write_register <= '0;
        Write_data     <= '0;
      end
    end else begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
      if (keep) begin
        if (count == 2'd0) begin
          q_reg[0]  <= req.in_Write_register;
          q_data[0] <= new_data;
        end else begin
          q_reg[1]  <= req.in_Write_register;
          q_data[1] <= new_data;
        end
        count <= count + 2'd1;
      end
    end
  end

endmodule
